// File: rtl/dataflow_bus_fabric_if.sv
// dataflow_bus_fabric_if
//
// Groups the control and data signals of the bus fabric. The register and
// address values are presented together with the buses they are built from.
//
// Parameters mirror the fabric: WIDTH, NUM_REGS, NUM_BUSES.
// SELW is the width of one bus-select field and is max(1, clog2(NUM_BUSES)).
//
// Modports
//   master : drives the controls (ext_in, ext_drive, reg_load, reg_load_sel,
//            reg_drive, reg_drive_sel, abl_load, abh_load, addr_inc,
//            contention_clr) and observes the results.
//   slave  : the fabric side; receives the controls and drives bus_value,
//            reg_value, addr_out and contention.
interface dataflow_bus_fabric_if #(
    parameter int WIDTH     = 8,
    parameter int NUM_REGS  = 4,
    parameter int NUM_BUSES = 3,
    parameter int SELW      = (NUM_BUSES > 1) ? $clog2(NUM_BUSES) : 1
);
    logic [WIDTH-1:0]            ext_in;
    logic [NUM_BUSES-1:0]        ext_drive;
    logic [NUM_REGS-1:0]         reg_load;
    logic [NUM_REGS*SELW-1:0]    reg_load_sel;
    logic [NUM_REGS-1:0]         reg_drive;
    logic [NUM_REGS*SELW-1:0]    reg_drive_sel;
    logic                        abl_load;
    logic                        abh_load;
    logic                        addr_inc;
    logic                        contention_clr;
    logic [NUM_BUSES*WIDTH-1:0]  bus_value;
    logic [NUM_REGS*WIDTH-1:0]   reg_value;
    logic [2*WIDTH-1:0]          addr_out;
    logic [NUM_BUSES-1:0]        contention;

    modport master (
        output ext_in, ext_drive, reg_load, reg_load_sel, reg_drive,
               reg_drive_sel, abl_load, abh_load, addr_inc, contention_clr,
        input  bus_value, reg_value, addr_out, contention
    );

    modport slave (
        input  ext_in, ext_drive, reg_load, reg_load_sel, reg_drive,
               reg_drive_sel, abl_load, abh_load, addr_inc, contention_clr,
        output bus_value, reg_value, addr_out, contention
    );
endinterface

// File: rtl/dataflow_bus_fabric.sv
// dataflow_bus_fabric
//
// A set of precharged internal buses with wired-AND resolution, a bank of
// general registers that load from and drive onto those buses, and an
// address latch pair (low/high) with a 2*WIDTH-bit incrementer.
//
// Ports
//   clk     : rising-edge clock
//   nrst    : synchronous active-low reset (clears registers, address and
//             contention flags)
//   bus_if  : dataflow_bus_fabric_if.slave carrying all controls and results
//             (bus_value is combinational, all other outputs registered)
//
// Configuration
//   DATAFLOW_CONTENTION_DETECT_EN : when defined, contention[b] becomes a
//   sticky flag set after any cycle with two or more drivers on bus b and
//   cleared by contention_clr (set wins). When undefined, contention is 0.
module dataflow_bus_fabric #(
    parameter int WIDTH     = 8,
    parameter int NUM_REGS  = 4,
    parameter int NUM_BUSES = 3,
    parameter int ABL_BUS   = 1,
    parameter int ABH_BUS   = 2
) (
    input  logic                  clk,
    input  logic                  nrst,
    dataflow_bus_fabric_if.slave  bus_if
);
    localparam int SELW = (NUM_BUSES > 1) ? $clog2(NUM_BUSES) : 1;

    logic [WIDTH-1:0]    regs     [NUM_REGS];
    logic [WIDTH-1:0]    bus      [NUM_BUSES];
    // drv[b][i] : register i drives bus b; drv[b][NUM_REGS] : ext_in drives bus b
    logic [NUM_REGS:0]   drv      [NUM_BUSES];
    logic [WIDTH-1:0]    load_val [NUM_REGS];
    logic [NUM_REGS-1:0] load_ok;
    logic [WIDTH-1:0]    addr_lo;
    logic [WIDTH-1:0]    addr_hi;

    // Out-of-range drive selects never match a real bus index, so they
    // simply produce no driver.
    always_comb begin
        for (int b = 0; b < NUM_BUSES; b++) begin
            drv[b] = '0;
            drv[b][NUM_REGS] = bus_if.ext_drive[b];
            for (int i = 0; i < NUM_REGS; i++) begin
                drv[b][i] = bus_if.reg_drive[i] &&
                            (bus_if.reg_drive_sel[i*SELW +: SELW] == SELW'(b));
            end
        end
    end

    // Precharged wired-AND: start at all-ones and pull down by each driver.
    always_comb begin
        for (int b = 0; b < NUM_BUSES; b++) begin
            bus[b] = '1;
            if (drv[b][NUM_REGS]) begin
                bus[b] = bus[b] & bus_if.ext_in;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                if (drv[b][i]) begin
                    bus[b] = bus[b] & regs[i];
                end
            end
        end
    end

    // Load source mux; a select outside the bus range leaves load_ok low so
    // the register holds. Registers read the pre-edge bus, so a register
    // driving and loading at once has no loop through itself.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            load_ok[i]  = 1'b0;
            load_val[i] = '0;
            for (int b = 0; b < NUM_BUSES; b++) begin
                if (bus_if.reg_load_sel[i*SELW +: SELW] == SELW'(b)) begin
                    load_ok[i]  = 1'b1;
                    load_val[i] = bus[b];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (bus_if.reg_load[i] && load_ok[i]) begin
                    regs[i] <= load_val[i];
                end
            end
        end
    end

    // Any latch load takes priority and the increment is dropped that cycle.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            addr_lo <= '0;
            addr_hi <= '0;
        end else if (bus_if.abl_load || bus_if.abh_load) begin
            if (bus_if.abl_load) begin
                addr_lo <= bus[ABL_BUS];
            end
            if (bus_if.abh_load) begin
                addr_hi <= bus[ABH_BUS];
            end
        end else if (bus_if.addr_inc) begin
            {addr_hi, addr_lo} <= {addr_hi, addr_lo} + (2*WIDTH)'(1);
        end
    end

`ifdef DATAFLOW_CONTENTION_DETECT_EN
    logic [NUM_BUSES-1:0] multi;
    logic [NUM_BUSES-1:0] cont_q;

    // Two or more drivers exactly when clearing the lowest set bit leaves
    // something behind.
    always_comb begin
        for (int b = 0; b < NUM_BUSES; b++) begin
            multi[b] = |(drv[b] & (drv[b] - (NUM_REGS+1)'(1)));
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cont_q <= '0;
        end else begin
            cont_q <= (bus_if.contention_clr ? '0 : cont_q) | multi;
        end
    end

    assign bus_if.contention = cont_q;
`else
    logic unused_contention_clr;
    assign unused_contention_clr = bus_if.contention_clr;
    assign bus_if.contention     = '0;
`endif

    for (genvar b = 0; b < NUM_BUSES; b++) begin : g_bus_out
        assign bus_if.bus_value[b*WIDTH +: WIDTH] = bus[b];
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
        assign bus_if.reg_value[i*WIDTH +: WIDTH] = regs[i];
    end

    assign bus_if.addr_out = {addr_hi, addr_lo};

endmodule

// File: tb/tb_dataflow_bus_fabric.sv
// tb_dataflow_bus_fabric
//
// Directed bench for dataflow_bus_fabric at the default parameters
// (WIDTH=8, NUM_REGS=4, NUM_BUSES=3, ABL_BUS=1, ABH_BUS=2).
// Contention expectations follow DATAFLOW_CONTENTION_DETECT_EN.
module tb_dataflow_bus_fabric;
    logic clk;
    logic nrst;
    int   tests_run;
    int   tests_failed;

`ifdef DATAFLOW_CONTENTION_DETECT_EN
    localparam bit CDET = 1'b1;
`else
    localparam bit CDET = 1'b0;
`endif

    dataflow_bus_fabric_if #(.WIDTH(8), .NUM_REGS(4), .NUM_BUSES(3)) bus_if ();

    dataflow_bus_fabric #(
        .WIDTH(8), .NUM_REGS(4), .NUM_BUSES(3), .ABL_BUS(1), .ABH_BUS(2)
    ) dut (
        .clk    (clk),
        .nrst   (nrst),
        .bus_if (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus_if.ext_in         = '0;
        bus_if.ext_drive      = '0;
        bus_if.reg_load       = '0;
        bus_if.reg_load_sel   = '0;
        bus_if.reg_drive      = '0;
        bus_if.reg_drive_sel  = '0;
        bus_if.abl_load       = 1'b0;
        bus_if.abh_load       = 1'b0;
        bus_if.addr_inc       = 1'b0;
        bus_if.contention_clr = 1'b0;
    endtask

    // One rising edge, then step just past it so outputs are settled.
    task automatic apply_stimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        nrst = 1'b0;
        clear_inputs();
        apply_stimulus();
        apply_stimulus();
        nrst = 1'b1;
        apply_stimulus();

        // Reset state with no drivers: precharged buses, cleared state
        check_output("reset_bus",  32'(bus_if.bus_value),  32'hFFFFFF);
        check_output("reset_regs", bus_if.reg_value,       32'h0000_0000);
        check_output("reset_addr", 32'(bus_if.addr_out),   32'h0000);
        check_output("reset_cont", 32'(bus_if.contention), 32'h0);

        // ext 0x5A on bus 0 loads reg 2
        bus_if.ext_in       = 8'h5A;
        bus_if.ext_drive    = 3'b001;
        bus_if.reg_load     = 4'b0100;
        bus_if.reg_load_sel = 8'b00_00_00_00;
        #1;
        check_output("ext_bus0", 32'(bus_if.bus_value), 32'hFFFF5A);
        apply_stimulus();
        check_output("reg2_load", bus_if.reg_value, 32'h005A_0000);

        // reg 2 drives bus 1 into the address low latch
        clear_inputs();
        bus_if.reg_drive     = 4'b0100;
        bus_if.reg_drive_sel = 8'b00_01_00_00;
        bus_if.abl_load      = 1'b1;
        #1;
        check_output("reg2_bus1", 32'(bus_if.bus_value), 32'hFF5AFF);
        apply_stimulus();
        check_output("abl_load", 32'(bus_if.addr_out), 32'h005A);

        // reg 0 = 0xF0, reg 1 = 0x3C via ext on bus 0
        clear_inputs();
        bus_if.ext_in    = 8'hF0;
        bus_if.ext_drive = 3'b001;
        bus_if.reg_load  = 4'b0001;
        apply_stimulus();
        bus_if.ext_in    = 8'h3C;
        bus_if.reg_load  = 4'b0010;
        apply_stimulus();
        check_output("regs01", bus_if.reg_value, 32'h005A_3CF0);

        // Both registers drive bus 0: wired-AND gives 0x30
        clear_inputs();
        bus_if.reg_drive     = 4'b0011;
        bus_if.reg_drive_sel = 8'b00_00_00_00;
        #1;
        check_output("and_bus0", 32'(bus_if.bus_value), 32'hFFFF30);
        check_output("cont_pre", 32'(bus_if.contention), 32'h0);
        apply_stimulus();
        clear_inputs();
        #1;
        check_output("cont_set", 32'(bus_if.contention), CDET ? 32'h1 : 32'h0);
        apply_stimulus();
        check_output("cont_sticky", 32'(bus_if.contention), CDET ? 32'h1 : 32'h0);

        // Clear together with a fresh double drive: set wins
        bus_if.reg_drive      = 4'b0011;
        bus_if.contention_clr = 1'b1;
        apply_stimulus();
        check_output("cont_set_wins", 32'(bus_if.contention), CDET ? 32'h1 : 32'h0);
        clear_inputs();
        bus_if.contention_clr = 1'b1;
        apply_stimulus();
        check_output("cont_clr", 32'(bus_if.contention), 32'h0);

        // Out-of-range selects: no drive, no load
        clear_inputs();
        bus_if.reg_drive     = 4'b0001;
        bus_if.reg_drive_sel = 8'b00_00_00_11;
        bus_if.reg_load      = 4'b0001;
        bus_if.reg_load_sel  = 8'b00_00_00_11;
        #1;
        check_output("sel3_nodrive", 32'(bus_if.bus_value), 32'hFFFFFF);
        apply_stimulus();
        check_output("sel3_hold", bus_if.reg_value, 32'h005A_3CF0);

        // Address 0x00FF: high from ext 0x00 on bus 2, low from precharged bus 1
        clear_inputs();
        bus_if.ext_in    = 8'h00;
        bus_if.ext_drive = 3'b100;
        bus_if.abl_load  = 1'b1;
        bus_if.abh_load  = 1'b1;
        bus_if.addr_inc  = 1'b1;
        apply_stimulus();
        check_output("addr_00ff", 32'(bus_if.addr_out), 32'h00FF);
        clear_inputs();
        bus_if.addr_inc = 1'b1;
        apply_stimulus();
        check_output("inc_carry", 32'(bus_if.addr_out), 32'h0100);

        // 0xFFFF wraps to 0x0000
        clear_inputs();
        bus_if.abl_load = 1'b1;
        bus_if.abh_load = 1'b1;
        apply_stimulus();
        check_output("addr_ffff", 32'(bus_if.addr_out), 32'hFFFF);
        clear_inputs();
        bus_if.addr_inc = 1'b1;
        apply_stimulus();
        check_output("inc_wrap", 32'(bus_if.addr_out), 32'h0000);
        apply_stimulus();
        check_output("inc_one", 32'(bus_if.addr_out), 32'h0001);

        // Increment discarded when abh_load of 0x12 coincides
        bus_if.ext_in    = 8'h12;
        bus_if.ext_drive = 3'b100;
        bus_if.abh_load  = 1'b1;
        bus_if.addr_inc  = 1'b1;
        apply_stimulus();
        check_output("abh_over_inc", 32'(bus_if.addr_out), 32'h1201);

        // reg 3 = 0xFF from precharged bus 2
        clear_inputs();
        bus_if.reg_load     = 4'b1000;
        bus_if.reg_load_sel = 8'b10_00_00_00;
        apply_stimulus();
        check_output("reg3_ff", bus_if.reg_value, 32'hFF5A_3CF0);

        // reg 3 drives and loads bus 2 while ext drives 0x0F
        bus_if.reg_drive     = 4'b1000;
        bus_if.reg_drive_sel = 8'b10_00_00_00;
        bus_if.ext_in        = 8'h0F;
        bus_if.ext_drive     = 3'b100;
        #1;
        check_output("bus2_and", 32'(bus_if.bus_value), 32'h0FFFFF);
        apply_stimulus();
        check_output("reg3_0f", bus_if.reg_value, 32'h0F5A_3CF0);
        check_output("cont_bus2", 32'(bus_if.contention), CDET ? 32'h4 : 32'h0);

        // Reset in the same cycle as load, increment and contention set
        bus_if.ext_in   = 8'h33;
        bus_if.addr_inc = 1'b1;
        nrst = 1'b0;
        apply_stimulus();
        check_output("rst_regs", bus_if.reg_value, 32'h0000_0000);
        check_output("rst_addr", 32'(bus_if.addr_out), 32'h0000);
        check_output("rst_cont", 32'(bus_if.contention), 32'h0);
        check_output("rst_bus", 32'(bus_if.bus_value), 32'h00FFFF);
        nrst = 1'b1;
        clear_inputs();
        apply_stimulus();
        check_output("post_rst_bus", 32'(bus_if.bus_value), 32'hFFFFFF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
